// File: rtl/fifo_ram.sv
// fifo_ram: storage array for fifo_sync.
// Synchronous write port, asynchronous read port.
//
// Ports:
//   i_clock  - write clock
//   i_wen    - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data (combinational from i_raddr)
module fifo_ram #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are deliberately not reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: parametrised single-clock FIFO with occupancy count,
// almost flags, sticky error flags, flush and optional FWFT read.
//
// Ports:
//   i_clock, i_reset      - clock; async active-high reset
//   i_flush               - synchronous clear of contents and errors
//   i_write, i_wdata      - push request and data
//   i_read                - pop request
//   o_rdata               - read data (registered, or head if FWFT)
//   o_empty, o_full       - occupancy 0 / DEPTH
//   o_almost_empty/full   - count <= AEMPTY_LEVEL / >= AFULL_LEVEL
//   o_count               - occupancy 0..DEPTH
//   o_overflow/underflow  - sticky rejected write / rejected read
module fifo_sync #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 64,
    parameter bit FWFT         = 1'b0,
    parameter int AFULL_LEVEL  = DEPTH - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_write,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_read,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_almost_empty,
    output logic                     o_almost_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AF_L = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AEMPTY_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be a power of two >= 2");
    end

    if (!((AEMPTY_LEVEL < AFULL_LEVEL) && (AFULL_LEVEL <= DEPTH)))
    begin : g_bad_levels
        $error("fifo_sync: need AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH");
    end

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_aempty;
    logic             r_afull;
    logic             r_ovf;
    logic             r_unf;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [PW-1:0]    w_count_nxt;
    logic             w_empty_nxt;
    logic             w_full_nxt;
    logic [WIDTH-1:0] w_ram_rdata;

    // Both sides judged against the pre-edge flags, so a full FIFO
    // rejects a same-cycle write and an empty one rejects the read.
    assign w_wr_acc = i_write && !r_full;
    assign w_rd_acc = i_read && !r_empty;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (i_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_wr_acc) begin
                w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + PW'(1);
                2'b01:   w_count_nxt = r_count - PW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Wrap bit distinguishes full from empty when indices match.
    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    assign w_full_nxt  =
        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
        (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= w_empty_nxt;
            r_full   <= w_full_nxt;
            r_aempty <= (w_count_nxt <= AE_L);
            r_afull  <= (w_count_nxt >= AF_L);
            if (i_flush) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (i_write && r_full) begin
                    r_ovf <= 1'b1;
                end
                if (i_read && r_empty) begin
                    r_unf <= 1'b1;
                end
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clock (i_clock),
        .i_wen   (w_wr_acc && !i_flush),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    if (FWFT) begin : g_fwft
        // Head entry is shown directly; meaningless while empty.
        assign o_rdata = w_ram_rdata;
    end else begin : g_reg
        logic [WIDTH-1:0] r_rdata;

        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                r_rdata <= '0;
            end else if (i_flush) begin
                r_rdata <= '0;
            end else if (w_rd_acc) begin
                r_rdata <= w_ram_rdata;
            end
        end

        assign o_rdata = r_rdata;
    end

    assign o_count        = r_count;
    assign o_empty        = r_empty;
    assign o_full         = r_full;
    assign o_almost_empty = r_aempty;
    assign o_almost_full  = r_afull;
    assign o_overflow     = r_ovf;
    assign o_underflow    = r_unf;

endmodule
